prng_request_scheduler: RTL and testbench
=========================================

Name: prng_request_scheduler

Overview:
Shares one 8-bit pseudo-random generator datapath (clear_InLow / load_InLow / 8-bit data bus) between two synchronous requesters. It arbitrates round-robin, sequences the generator's active-low clear and load strobes, captures the generated word and returns it with a one-cycle acknowledge. It also services reseed (clear) requests. It sits between the consumer logic and the generator inside the top-level system.

Parameters:
DATAWIDTH, 8, width of generator data bus and response data
GEN_LATENCY, 1, cycles from the load-strobe cycle to the cycle in which gen_data_InBUS is valid (legal 1..15)
CLEAR_CYCLES, 2, number of consecutive cycles gen_clear_InLow is held low per reseed (legal 1..15)
COUNTWIDTH, 16, width of delivered-word counter

Ports:
PRNGSCHED_CLOCK_50  input  1  system clock, all logic on rising edge
PRNGSCHED_RESET_InLow  input  1  synchronous active-low reset
req0  input  1  requester 0 wants one word; held high until ack0
req1  input  1  requester 1 wants one word; held high until ack1
clr_req  input  1  one-cycle pulse: reseed generator
ack0  output  1  one-cycle pulse, rsp_data valid for requester 0
ack1  output  1  one-cycle pulse, rsp_data valid for requester 1
rsp_data  output  DATAWIDTH  captured generator word
clr_done  output  1  one-cycle pulse when reseed finished
busy  output  1  high whenever FSM not in IDLE
gen_count  output  COUNTWIDTH  total words delivered since reset
gen_clear_InLow  output  1  to generator clear input, active low
gen_load_InLow  output  1  to generator load/step input, active low
gen_data_InBUS  input  DATAWIDTH  generator output bus

Behaviour:
- Interface: one clock; reset is synchronous and active-low (PRNGSCHED_RESET_InLow sampled on PRNGSCHED_CLOCK_50 rising edge). All outputs are registered.
- Reset values: ack0=ack1=0, clr_done=0, busy=0, rsp_data=0, gen_count=0, gen_clear_InLow=1, gen_load_InLow=1, clr_pending=0, last_grant=1 (so requester 0 wins first tie), state=IDLE.
- Reset mid-operation: all of the above take effect on that edge. Any in-flight grant or pending clear is dropped and no ack is issued.
- FSM states: IDLE, CLEAR, LOAD, WAIT, ACK.
- clr_req: sets clr_pending on any cycle, in any state. Multiple pulses before service merge into one reseed.
- IDLE: if clr_pending, go to CLEAR. Clear has priority over requests. Else if any req, grant and go to LOAD. Else stay in IDLE.
- Grant is round-robin. If only one req is high, that requester is granted. If both are high, the requester other than last_grant is granted. last_grant updates on grant.
- CLEAR: gen_clear_InLow=0 for exactly CLEAR_CYCLES cycles (counter). clr_pending clears on entry. clr_done=1 in the cycle after the last low cycle, together with return to IDLE. A clr_req arriving during CLEAR sets clr_pending again.
- LOAD: gen_load_InLow=0 for exactly one cycle, then WAIT.
- WAIT: lasts GEN_LATENCY cycles. In the last WAIT cycle, gen_data_InBUS is sampled into rsp_data.
- ACK: ackN=1 for the granted requester for one cycle. rsp_data holds the captured word and keeps it until the next capture. gen_count increments by 1, wrapping from 2^COUNTWIDTH-1 to 0. Next state is IDLE.
- Timing: req sampled in IDLE at cycle N gives load strobe at N+1 and ack at N+2+GEN_LATENCY. With defaults, ack is at N+3, for 4-cycle throughput per word.
- Requester contract: deassert req the cycle after ack. A req still high in the IDLE cycle after ack is treated as a new request, which is legal for back-to-back.
- gen_clear_InLow and gen_load_InLow are never low in the same cycle.
- busy=1 in CLEAR, LOAD, WAIT, ACK.

Test Plan:
1. Reset: hold PRNGSCHED_RESET_InLow=0 for 2 cycles with req0=req1=1 -> all outputs at reset values, gen_*_InLow=1, no ack; after release, first grant goes to requester 0.
2. Single request: req0=1 at cycle 10, gen_data_InBUS=8'hA5 at cycle 12 -> gen_load_InLow=0 only in cycle 11; ack0=1 in cycle 13 with rsp_data=8'hA5; gen_count=1.
3. Contention: req0=req1=1 held continuously for 4 grants -> ack order 0,1,0,1, each 4 cycles apart; gen_count=4.
4. Clear priority: clr_req pulse during WAIT of a req1 transaction, plus req0 pending -> ack1 first; then gen_clear_InLow=0 for 2 cycles; clr_done pulse; only then the req0 load strobe.
5. Merged clears: three clr_req pulses within 3 cycles while idle-to-busy -> only one CLEAR sequence (2 low cycles) and one clr_done, provided no pulse arrives after CLEAR entry.
6. Reset mid-op: assert reset in WAIT (GEN_LATENCY=3 build) -> no ack issued, gen_count keeps its reset value of 0, FSM returns to IDLE; a following req completes normally; counter wrap checked with COUNTWIDTH=2: fifth ack gives gen_count=1.

Source files
------------

// File: rtl/prng_request_scheduler.sv
// prng_request_scheduler
// Lets two synchronous requesters share one 8-bit pseudo-random generator.
// Requests are granted round-robin. The block drives the generator's
// active-low clear and load strobes, captures the generated word, and
// returns it to the granted requester with a one-cycle acknowledge. Reseed
// (clear) requests are queued as a single pending flag and take priority
// over word requests.
//
// Ports
//   PRNGSCHED_CLOCK_50     system clock, rising edge
//   PRNGSCHED_RESET_InLow  synchronous active-low reset
//   req0 / req1            word requests, held high until the matching ack
//   clr_req                one-cycle reseed request pulse
//   ack0 / ack1            one-cycle acknowledge, rsp_data valid
//   rsp_data               last captured generator word
//   clr_done               one-cycle pulse when a reseed completes
//   busy                   high whenever the controller is not idle
//   gen_count              words delivered since reset (wraps)
//   gen_clear_InLow        generator clear strobe, active low
//   gen_load_InLow         generator load/step strobe, active low
//   gen_data_InBUS         generator output word
//
// States
//   state | meaning
//   IDLE  | waiting; reseed has priority over word requests
//   CLEAR | gen_clear_InLow held low for CLEAR_CYCLES cycles
//   LOAD  | gen_load_InLow low for one cycle
//   WAIT  | GEN_LATENCY cycles; word captured in the last one
//   ACK   | ack pulse to the granted requester, gen_count bumped
module prng_request_scheduler #(
    parameter int DATAWIDTH    = 8,
    parameter int GEN_LATENCY  = 1,
    parameter int CLEAR_CYCLES = 2,
    parameter int COUNTWIDTH   = 16
) (
    input  logic                  PRNGSCHED_CLOCK_50,
    input  logic                  PRNGSCHED_RESET_InLow,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  clr_req,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATAWIDTH-1:0]  rsp_data,
    output logic                  clr_done,
    output logic                  busy,
    output logic [COUNTWIDTH-1:0] gen_count,
    output logic                  gen_clear_InLow,
    output logic                  gen_load_InLow,
    input  logic [DATAWIDTH-1:0]  gen_data_InBUS
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] ACK   = 3'd4;

    localparam int TIMERWIDTH = 4;

    logic [2:0]            state;
    logic [2:0]            nextState;
    logic [TIMERWIDTH-1:0] stepTimer;
    logic                  timerDone;
    logic                  clrPending;
    logic                  lastGrant;
    logic                  curGrant;
    logic                  grantNext;
    logic                  enterClear;
    logic                  enterLoad;
    logic                  enterAck;

    assign timerDone = (stepTimer == '0);

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (clrPending) begin
                    nextState = CLEAR;
                end else if (req0 || req1) begin
                    nextState = LOAD;
                end
            end
            CLEAR:   if (timerDone) nextState = IDLE;
            LOAD:    nextState = WAIT;
            WAIT:    if (timerDone) nextState = ACK;
            ACK:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Round-robin: on a tie the requester that did not win last time wins;
    // otherwise whichever single requester is asking.
    always_comb begin
        grantNext = req1;
        if (req0 && req1) begin
            grantNext = ~lastGrant;
        end
    end

    assign enterClear = (state == IDLE) && (nextState == CLEAR);
    assign enterLoad  = (state == IDLE) && (nextState == LOAD);
    assign enterAck   = (state == WAIT) && (nextState == ACK);

    always_ff @(posedge PRNGSCHED_CLOCK_50) begin
        if (!PRNGSCHED_RESET_InLow) begin
            state           <= IDLE;
            stepTimer       <= '0;
            clrPending      <= 1'b0;
            lastGrant       <= 1'b1;
            curGrant        <= 1'b0;
            ack0            <= 1'b0;
            ack1            <= 1'b0;
            rsp_data        <= '0;
            clr_done        <= 1'b0;
            busy            <= 1'b0;
            gen_count       <= '0;
            gen_clear_InLow <= 1'b1;
            gen_load_InLow  <= 1'b1;
        end else begin
            state <= nextState;
            busy  <= (nextState != IDLE);

            // Strobes are a registered decode of the next state, so they are
            // low for exactly the cycles spent in CLEAR / LOAD and can never
            // overlap.
            gen_clear_InLow <= (nextState != CLEAR);
            gen_load_InLow  <= (nextState != LOAD);

            clr_done <= (state == CLEAR) && (nextState == IDLE);

            // A pulse arriving in the same cycle the reseed starts is served
            // by that reseed; any later pulse re-arms the flag.
            if (enterClear) begin
                clrPending <= 1'b0;
            end else if (clr_req) begin
                clrPending <= 1'b1;
            end

            if (enterClear) begin
                stepTimer <= TIMERWIDTH'(CLEAR_CYCLES - 1);
            end else if (state == LOAD) begin
                stepTimer <= TIMERWIDTH'(GEN_LATENCY - 1);
            end else if (!timerDone) begin
                stepTimer <= stepTimer - TIMERWIDTH'(1);
            end

            if (enterLoad) begin
                curGrant  <= grantNext;
                lastGrant <= grantNext;
            end

            ack0 <= enterAck && !curGrant;
            ack1 <= enterAck && curGrant;
            if (enterAck) begin
                rsp_data  <= gen_data_InBUS;
                gen_count <= gen_count + COUNTWIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_prng_request_scheduler.sv
// Bench for prng_request_scheduler. Two instances run side by side: one with
// default parameters and one with GEN_LATENCY=3, CLEAR_CYCLES=3, COUNTWIDTH=2.
// A transaction-level model predicts strobes, busy, clr_done and acks; the
// generator itself is emulated by driving the predicted word only in the
// cycle it is supposed to be valid.
module tb_prng_request_scheduler;

    localparam int NI = 2;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] data;
        int         count;
    } ackExp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rstN     [NI];
    logic       req0     [NI];
    logic       req1     [NI];
    logic       clrReq   [NI];
    logic       ack0     [NI];
    logic       ack1     [NI];
    logic [7:0] rspData  [NI];
    logic       clrDone  [NI];
    logic       busy     [NI];
    logic       genClearN[NI];
    logic       genLoadN [NI];
    logic [7:0] genData  [NI];
    logic [15:0] genCountA;
    logic [1:0]  genCountB;

    prng_request_scheduler #(
        .DATAWIDTH(8), .GEN_LATENCY(1), .CLEAR_CYCLES(2), .COUNTWIDTH(16)
    ) dutA (
        .PRNGSCHED_CLOCK_50(clk), .PRNGSCHED_RESET_InLow(rstN[0]),
        .req0(req0[0]), .req1(req1[0]), .clr_req(clrReq[0]),
        .ack0(ack0[0]), .ack1(ack1[0]), .rsp_data(rspData[0]),
        .clr_done(clrDone[0]), .busy(busy[0]), .gen_count(genCountA),
        .gen_clear_InLow(genClearN[0]), .gen_load_InLow(genLoadN[0]),
        .gen_data_InBUS(genData[0])
    );

    prng_request_scheduler #(
        .DATAWIDTH(8), .GEN_LATENCY(3), .CLEAR_CYCLES(3), .COUNTWIDTH(2)
    ) dutB (
        .PRNGSCHED_CLOCK_50(clk), .PRNGSCHED_RESET_InLow(rstN[1]),
        .req0(req0[1]), .req1(req1[1]), .clr_req(clrReq[1]),
        .ack0(ack0[1]), .ack1(ack1[1]), .rsp_data(rspData[1]),
        .clr_done(clrDone[1]), .busy(busy[1]), .gen_count(genCountB),
        .gen_clear_InLow(genClearN[1]), .gen_load_InLow(genLoadN[1]),
        .gen_data_InBUS(genData[1])
    );

    int vectors = 0;
    int miscompares = 0;

    // model parameters per instance
    int lat   [NI] = '{1, 3};
    int ccy   [NI] = '{2, 3};
    int cmask [NI] = '{65535, 3};

    // model state per instance
    int freeAt [NI];
    bit lastG  [NI];
    bit pend   [NI];
    int mCount [NI];
    bit rstPrev[NI];

    // requester / stimulus controls
    int want0  [NI];
    int want1  [NI];
    bit doClr  [NI];
    bit doRst  [NI];

    // per-cycle expectations keyed by cycle*2+instance
    bit         expLoad [int];
    bit         expClear[int];
    bit         expDone [int];
    bit         expBusy [int];
    logic [7:0] dataAt  [int];

    ackExp_t ackQ0[$];
    ackExp_t ackQ1[$];

    function automatic int k(int t, int i);
        return t * 2 + i;
    endfunction

    function automatic logic [15:0] genCnt(int i);
        return (i == 0) ? genCountA : {14'd0, genCountB};
    endfunction

    function automatic int qSize(int i);
        return (i == 0) ? ackQ0.size() : ackQ1.size();
    endfunction

    function automatic ackExp_t qFront(int i);
        return (i == 0) ? ackQ0[0] : ackQ1[0];
    endfunction

    task automatic qPush(input int i, input ackExp_t e);
        if (i == 0) ackQ0.push_back(e);
        else        ackQ1.push_back(e);
    endtask

    task automatic qPop(input int i, output ackExp_t e);
        if (i == 0) e = ackQ0.pop_front();
        else        e = ackQ1.pop_front();
    endtask

    task automatic qDropAfter(input int i, input int t);
        if (i == 0) begin
            while (ackQ0.size() > 0 && ackQ0[ackQ0.size()-1].cyc > t) void'(ackQ0.pop_back());
        end else begin
            while (ackQ1.size() > 0 && ackQ1[ackQ1.size()-1].cyc > t) void'(ackQ1.pop_back());
        end
    endtask

    task automatic check(input string name, input int i,
                         input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s inst%0d cycle %0d: got 0x%0h, want 0x%0h",
                     name, i, cyc, actual, expected);
        end
    endtask

    // Transaction-level reference: each cycle the scheduler is free it
    // either starts a reseed (CLEAR_CYCLES low cycles, done pulse after) or
    // grants a word (load next cycle, data latency later, ack one after that).
    task automatic modelStep(input int i, input int t, input bit rstLow,
                             input bit r0, input bit r1, input bit clr);
        bit started;
        started = 1'b0;
        if (rstLow) begin
            for (int c = t + 1; c <= t + 40; c++) begin
                expLoad.delete(k(c, i));
                expClear.delete(k(c, i));
                expDone.delete(k(c, i));
                expBusy.delete(k(c, i));
            end
            qDropAfter(i, t);
            freeAt[i] = t + 1;
            lastG[i]  = 1'b1;
            pend[i]   = 1'b0;
            mCount[i] = 0;
            return;
        end
        if (t >= freeAt[i]) begin
            if (pend[i]) begin
                for (int c = 1; c <= ccy[i]; c++) begin
                    expClear[k(t + c, i)] = 1'b1;
                    expBusy[k(t + c, i)]  = 1'b1;
                end
                expDone[k(t + ccy[i] + 1, i)] = 1'b1;
                freeAt[i] = t + ccy[i] + 1;
                pend[i]   = 1'b0;
                started   = 1'b1;
            end else if (r0 || r1) begin
                int g;
                ackExp_t e;
                g = (r0 && r1) ? (lastG[i] ? 0 : 1) : (r1 ? 1 : 0);
                lastG[i] = (g == 1);
                for (int c = 1; c <= 2 + lat[i]; c++) expBusy[k(t + c, i)] = 1'b1;
                expLoad[k(t + 1, i)] = 1'b1;
                e.data = 8'($urandom);
                dataAt[k(t + 1 + lat[i], i)] = e.data;
                mCount[i] = (mCount[i] + 1) & cmask[i];
                e.cyc   = t + 2 + lat[i];
                e.id    = g;
                e.count = mCount[i];
                qPush(i, e);
                freeAt[i] = t + 3 + lat[i];
            end
        end
        if (clr && !started) pend[i] = 1'b1;
    endtask

    // One stimulus cycle: requesters react to acks, inputs are driven, and
    // the model is advanced with exactly what was applied.
    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            if (rstPrev[i]) begin
                check("rst_rsp_data", i, rspData[i], 0);
                check("rst_gen_count", i, genCnt(i), 0);
                check("rst_ack", i, {ack0[i], ack1[i]}, 0);
            end
            if (ack0[i] === 1'b1 && want0[i] > 0) want0[i]--;
            if (ack1[i] === 1'b1 && want1[i] > 0) want1[i]--;
            req0[i]   = (want0[i] > 0);
            req1[i]   = (want1[i] > 0);
            clrReq[i] = doClr[i];
            rstN[i]   = !doRst[i];
            genData[i] = dataAt.exists(k(cyc, i)) ? dataAt[k(cyc, i)] : 8'($urandom);
            modelStep(i, cyc, doRst[i], req0[i], req1[i], doClr[i]);
            rstPrev[i] = doRst[i];
            doClr[i] = 1'b0;
            doRst[i] = 1'b0;
        end
    endtask

    function automatic bit allQuiet();
        for (int i = 0; i < NI; i++) begin
            if (want0[i] != 0 || want1[i] != 0 || pend[i] || cyc < freeAt[i] || qSize(i) != 0)
                return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain();
        int n;
        n = 0;
        while (!allQuiet() && n < 300) begin
            step();
            n++;
        end
        if (!allQuiet()) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout cycle %0d: got requests still outstanding, want all served", cyc);
        end
        step();
        step();
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin : monitor
        ackExp_t e;
        if (cyc >= 2) begin
            for (int i = 0; i < NI; i++) begin
                check("gen_load_InLow", i, genLoadN[i], !expLoad.exists(k(cyc, i)));
                check("gen_clear_InLow", i, genClearN[i], !expClear.exists(k(cyc, i)));
                check("clr_done", i, clrDone[i], expDone.exists(k(cyc, i)));
                check("busy", i, busy[i], expBusy.exists(k(cyc, i)));
                if (ack0[i] === 1'b1 || ack1[i] === 1'b1) begin
                    if (qSize(i) == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_ack inst%0d cycle %0d: got ack0=%0b ack1=%0b, want none",
                                 i, cyc, ack0[i], ack1[i]);
                    end else begin
                        qPop(i, e);
                        check("ack_cycle", i, cyc, e.cyc);
                        check("ack_exclusive", i, ack0[i] & ack1[i], 0);
                        check("ack_id", i, ack1[i], e.id);
                        check("rsp_data", i, rspData[i], e.data);
                        check("gen_count", i, genCnt(i), e.count);
                    end
                end else if (qSize(i) > 0 && qFront(i).cyc < cyc) begin
                    qPop(i, e);
                    vectors++;
                    miscompares++;
                    $display("FAIL missing_ack inst%0d cycle %0d: got no ack, want ack%0d at cycle %0d",
                             i, cyc, e.id, e.cyc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout cycle %0d: got no finish, want finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rstN[i] = 1'b0; req0[i] = 1'b0; req1[i] = 1'b0; clrReq[i] = 1'b0;
            genData[i] = 8'd0;
            freeAt[i] = 0; lastG[i] = 1'b1; pend[i] = 1'b0; mCount[i] = 0;
            rstPrev[i] = 1'b1;
            want0[i] = 0; want1[i] = 0; doClr[i] = 1'b0; doRst[i] = 1'b0;
        end

        // reset held two cycles with both requests up; requester 0 wins first
        for (int i = 0; i < NI; i++) begin want0[i] = 1; want1[i] = 1; end
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < NI; i++) doRst[i] = 1'b1;
            step();
        end
        drain();

        // single request
        for (int i = 0; i < NI; i++) want0[i] = 1;
        drain();

        // contention: alternating grants
        for (int i = 0; i < NI; i++) begin want0[i] = 2; want1[i] = 2; end
        drain();

        // reseed requested during a requester-1 transaction with req0 waiting
        for (int i = 0; i < NI; i++) want1[i] = 1;
        step();
        step();
        for (int i = 0; i < NI; i++) begin doClr[i] = 1'b1; want0[i] = 1; end
        step();
        drain();

        // three clear pulses while busy merge into one reseed
        for (int i = 0; i < NI; i++) want0[i] = 1;
        step();
        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < NI; i++) doClr[i] = 1'b1;
            step();
        end
        drain();

        // reset in WAIT on the long-latency instance, then counter wrap
        want0[1] = 1;
        step();
        step();
        step();
        doRst[1] = 1'b1;
        step();
        drain();
        want0[1] = 5;
        drain();

        // randomized traffic with occasional reseeds and resets
        for (int n = 0; n < 500; n++) begin
            for (int i = 0; i < NI; i++) begin
                if (want0[i] == 0 && $urandom_range(0, 3) == 0) want0[i] = $urandom_range(1, 3);
                if (want1[i] == 0 && $urandom_range(0, 3) == 0) want1[i] = $urandom_range(1, 3);
                if ($urandom_range(0, 15) == 0) doClr[i] = 1'b1;
                if ($urandom_range(0, 199) == 0) doRst[i] = 1'b1;
            end
            step();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
